// File: rtl/procesador_fifo_csr.sv
// procesador_fifo_csr: Avalon-ST sample FIFO in inferred RAM, with a
// four-word Avalon-MM CSR slave (pop, status, threshold, control).
//
// Ports:
//   wrclock, reset                 single clock, sync active-high reset
//   avalonst_sink_data/valid       sample stream in
//   avalonst_sink_ready            !full, from the registered level
//   avalonmm_read_slave_address    word address (0 pop, 1 status,
//                                  2 thresh, 3 ctrl)
//   avalonmm_read_slave_read       read strobe (wins over write)
//   avalonmm_read_slave_write      write strobe
//   avalonmm_read_slave_writedata  write data
//   avalonmm_read_slave_readdata   registered read data, latency 1
//   irq                            registered level-threshold interrupt
module procesador_fifo_csr #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 7,
   parameter int THRESH_DEFAULT = 64
) (
   input  logic              wrclock,
   input  logic              reset,
   input  logic [DATA_W-1:0] avalonst_sink_data,
   input  logic              avalonst_sink_valid,
   output logic              avalonst_sink_ready,
   input  logic [1:0]        avalonmm_read_slave_address,
   input  logic              avalonmm_read_slave_read,
   input  logic              avalonmm_read_slave_write,
   input  logic [31:0]       avalonmm_read_slave_writedata,
   output logic [31:0]       avalonmm_read_slave_readdata,
   output logic              irq
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] PTR_ONE = 1;
   localparam logic [ADDR_W:0] LVL_ONE = 1;
   localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] THR_RST = (ADDR_W+1)'(THRESH_DEFAULT);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   level;
   logic [ADDR_W:0]   thresh;
   logic [15:0]       drop_cnt;
   logic              overflow;
   logic              underflow;
   logic              irq_en;

   logic        empty, full;
   logic        rd_en, wr_en;
   logic        flush, clr;
   logic        pop_req, push, pop;
   logic        ovf_ev, unf_ev;
   logic [31:0] rd_word;
   logic [31:0] status_word;
   logic [31:0] ctrl_word;
   logic        unused_wdata;

   assign empty = (level == '0);
   assign full  = (level == LVL_FULL);
   assign avalonst_sink_ready = !full;

   // A simultaneous read strobe suppresses the write.
   assign rd_en = avalonmm_read_slave_read;
   assign wr_en = avalonmm_read_slave_write & ~avalonmm_read_slave_read;

   assign flush = wr_en & (avalonmm_read_slave_address == 2'd3)
                  & avalonmm_read_slave_writedata[0];
   assign clr   = wr_en & (avalonmm_read_slave_address == 2'd3)
                  & avalonmm_read_slave_writedata[1];

   // Flush swallows any push/pop in its cycle without raising flags.
   assign pop_req = rd_en & (avalonmm_read_slave_address == 2'd0);
   assign push    = avalonst_sink_valid & !full & !flush;
   assign pop     = pop_req & !empty & !flush;
   assign ovf_ev  = avalonst_sink_valid & full & !flush;
   assign unf_ev  = pop_req & empty & !flush;

   assign rd_word = 32'(mem[rd_ptr]);
   assign status_word = {11'd0, irq, underflow, overflow,
                         full, empty, 16'(level)};
   assign ctrl_word = {drop_cnt, 13'd0, irq_en, 2'd0};

   assign unused_wdata = ^avalonmm_read_slave_writedata[31:ADDR_W+1];

   always_ff @(posedge wrclock) begin
      if (push) mem[wr_ptr] <= avalonst_sink_data;
   end

   always_ff @(posedge wrclock) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         thresh    <= THR_RST;
         drop_cnt  <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         irq_en    <= 1'b0;
         irq       <= 1'b0;
         avalonmm_read_slave_readdata <= '0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push & !pop)      level <= level + LVL_ONE;
            else if (pop & !push) level <= level - LVL_ONE;
         end

         // A new event in the clear cycle takes priority over the clear.
         if (ovf_ev)   overflow <= 1'b1;
         else if (clr) overflow <= 1'b0;
         if (unf_ev)   underflow <= 1'b1;
         else if (clr) underflow <= 1'b0;

         if (clr)
            drop_cnt <= ovf_ev ? 16'd1 : 16'd0;
         else if (ovf_ev && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;

         if (wr_en && avalonmm_read_slave_address == 2'd2)
            thresh <= avalonmm_read_slave_writedata[ADDR_W:0];
         if (wr_en && avalonmm_read_slave_address == 2'd3)
            irq_en <= avalonmm_read_slave_writedata[2];

         irq <= irq_en & (thresh != '0) & (level >= thresh);

         if (rd_en) begin
            unique case (avalonmm_read_slave_address)
               2'd0: avalonmm_read_slave_readdata <= pop ? rd_word : '0;
               2'd1: avalonmm_read_slave_readdata <= status_word;
               2'd2: avalonmm_read_slave_readdata <= 32'(thresh);
               2'd3: avalonmm_read_slave_readdata <= ctrl_word;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_procesador_fifo_csr.sv
// tb_procesador_fifo_csr: directed bench with a readdata scoreboard.
// Ports: none (drives procesador_fifo_csr with default parameters).
module tb_procesador_fifo_csr;

   logic        wrclock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] sink_data = '0;
   logic        sink_valid = 1'b0;
   logic        sink_ready;
   logic [1:0]  addr = '0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] readdata;
   logic        irq;

   typedef struct {
      logic [31:0] val;
      string       nm;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 wrclock = ~wrclock;

   procesador_fifo_csr dut (
      .wrclock                       (wrclock),
      .reset                         (reset),
      .avalonst_sink_data            (sink_data),
      .avalonst_sink_valid           (sink_valid),
      .avalonst_sink_ready           (sink_ready),
      .avalonmm_read_slave_address   (addr),
      .avalonmm_read_slave_read      (read),
      .avalonmm_read_slave_write     (write),
      .avalonmm_read_slave_writedata (wdata),
      .avalonmm_read_slave_readdata  (readdata),
      .irq                           (irq)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   // Monitor: every read strobe seen at an edge yields readdata #1 later.
   always @(posedge wrclock) begin
      if (!reset && read) begin
         #1;
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_read: got 0x%08h, expected none",
                     readdata);
         end else begin
            mon_e = exp_q.pop_front();
            chk(mon_e.nm, readdata, mon_e.val);
         end
      end
   end

   task automatic tick();
      @(negedge wrclock);
   endtask

   task automatic push(input logic [31:0] d);
      sink_valid = 1'b1;
      sink_data = d;
      tick();
      sink_valid = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] e,
                     input string nm);
      addr = a;
      read = 1'b1;
      exp_q.push_back('{e, nm});
      tick();
      read = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      addr = a;
      wdata = d;
      write = 1'b1;
      tick();
      write = 1'b0;
   endtask

   initial begin
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_ready", 32'(sink_ready), 32'd1);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_readdata", readdata, 32'd0);
      rd(2'd1, 32'h0001_0000, "rst_status");
      rd(2'd2, 32'd64, "rst_thresh");
      rd(2'd3, 32'd0, "rst_ctrl");

      // 1: basic order
      push(32'h11);
      push(32'h22);
      push(32'h33);
      rd(2'd1, 32'h0000_0003, "t1_status_l3");
      rd(2'd0, 32'h11, "t1_pop0");
      rd(2'd0, 32'h22, "t1_pop1");
      rd(2'd0, 32'h33, "t1_pop2");
      rd(2'd1, 32'h0001_0000, "t1_status_empty");

      // 2: fill past full
      sink_valid = 1'b1;
      for (int i = 0; i < 130; i++) begin
         sink_data = 32'h1000 + i;
         chk("t2_ready", 32'(sink_ready), (i < 128) ? 32'd1 : 32'd0);
         tick();
      end
      sink_valid = 1'b0;
      rd(2'd1, 32'h0006_0080, "t2_status_full");
      rd(2'd3, 32'h0002_0000, "t2_drop2");
      for (int i = 0; i < 128; i++) rd(2'd0, 32'h1000 + i, "t2_data");
      rd(2'd1, 32'h0005_0000, "t2_status_drained");

      // 3: underflow, clear, threshold width
      rd(2'd0, 32'd0, "t3_pop_empty");
      rd(2'd1, 32'h000D_0000, "t3_status_flags");
      wr(2'd3, 32'h2);
      rd(2'd1, 32'h0001_0000, "t3_status_clr");
      rd(2'd3, 32'd0, "t3_ctrl_clr");
      wr(2'd2, 32'hFFFF_FF05);
      rd(2'd2, 32'h05, "t3_thresh_mask");

      // 4: irq threshold
      wr(2'd2, 32'd4);
      rd(2'd2, 32'd4, "t4_thresh");
      wr(2'd3, 32'h4);
      for (int i = 0; i < 4; i++) begin
         push(32'hA0 + i);
         chk("t4_irq_low", 32'(irq), 32'd0);
      end
      tick();
      chk("t4_irq_rise", 32'(irq), 32'd1);
      rd(2'd1, 32'h0010_0004, "t4_status_irq");
      rd(2'd0, 32'hA0, "t4_pop");
      chk("t4_irq_lag", 32'(irq), 32'd1);
      tick();
      chk("t4_irq_fall", 32'(irq), 32'd0);
      addr = 2'd2;
      wdata = 32'd9;
      write = 1'b1;
      rd(2'd2, 32'd4, "t4_rdwr_read");
      write = 1'b0;
      rd(2'd2, 32'd4, "t4_rdwr_nowrite");

      // 5: flush with concurrent push
      for (int i = 0; i < 7; i++) push(32'hB0 + i);
      tick();
      chk("t5_irq_10", 32'(irq), 32'd1);
      sink_valid = 1'b1;
      sink_data = 32'hCC;
      wr(2'd3, 32'h5);
      sink_valid = 1'b0;
      tick();
      rd(2'd1, 32'h0001_0000, "t5_status_flush");
      rd(2'd3, 32'h4, "t5_ctrl");
      push(32'hD0);
      rd(2'd0, 32'hD0, "t5_pop_after_flush");

      // 6: full push+pop, then continuous wrapping traffic
      wr(2'd3, 32'h2);
      for (int i = 0; i < 128; i++) push(32'h2000 + i);
      sink_valid = 1'b1;
      sink_data = 32'hDEAD;
      rd(2'd0, 32'h2000, "t6_full_pushpop");
      sink_valid = 1'b0;
      rd(2'd3, 32'h0001_0000, "t6_drop1");
      rd(2'd1, 32'h0004_007F, "t6_status");
      addr = 2'd0;
      for (int i = 0; i < 384; i++) begin
         sink_valid = 1'b1;
         sink_data = 32'h3000 + i;
         rd(2'd0, (i < 127) ? 32'h2001 + i : 32'h3000 + i - 127,
            "t6_wrap");
      end
      sink_valid = 1'b0;
      rd(2'd1, 32'h0004_007F, "t6_status_end");

      repeat (3) tick();
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
